// File: rtl/router_pkg.sv
// Shared definitions for the router packet register: default parameter
// values, header field positions, the dout source selector and the
// running parity helper.
package router_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 2;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_HOLD_DEPTH = 2;

  // Destination address sits in the low header bits; the payload length
  // (when length checking is built in) occupies everything above it.
  localparam int HDR_ADDR_LSB = 0;

  // Widest byte the parity helper folds; DATA_W must not exceed it.
  localparam int PAR_MAX_W = 32;

  // Which value is loaded into dout on the next edge.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HDR,
    SRC_DIN,
    SRC_BUF
  } dout_src_e;

  // Running even parity: XOR each accepted byte into the accumulator.
  function automatic logic [PAR_MAX_W-1:0] parity_fold(
    input logic [PAR_MAX_W-1:0] acc,
    input logic [PAR_MAX_W-1:0] data
  );
    return acc ^ data;
  endfunction

endpackage

// File: rtl/router_pkt_reg_if.sv
// Byte stream between the router input, the packet register and the
// selected channel FIFO. The master side sources bytes and reports FIFO
// fullness; the slave side (the packet register) drives the FIFO write.
interface router_pkt_reg_if #(
  parameter int DATA_W = 8
) ();

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport master (
    output pkt_valid,
    output data_in,
    output fifo_full,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    input  fifo_full,
    output dout,
    output dout_valid
  );

endinterface

// File: rtl/router_hold_buf.sv
// Small synchronous FIFO that parks payload bytes while the channel FIFO
// is full. The caller only pushes when there is room (or a pop happens in
// the same cycle), so no overflow protection lives here.
module router_hold_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write.
  // NOTE: the storage array has no reset; the pointers and count decide
  // which entries are valid, so clearing them is enough.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; push and pop together keep the count.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet datapath register. Latches the header, forwards header and
// payload bytes to the channel FIFO, parks bytes in a holding buffer while
// the FIFO is full, and checks the running XOR parity against the trailing
// parity byte. All sequencing comes from the router FSM strobes.
// Optional feature: define PKT_LEN_CHECK_EN to count payload bytes and
// flag a mismatch against the length field in the header upper bits.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int HOLD_DEPTH = DEF_HOLD_DEPTH
) (
  input  logic                clock,
  input  logic                resetn,
  router_pkt_reg_if.slave     bus,
  input  logic                detect_add,
  input  logic                lfd_state,
  input  logic                ld_state,
  input  logic                laf_state,
  input  logic                full_state,
  input  logic                rst_int_reg,
  output logic                hold_empty,
  output logic                hold_ovf,
  output logic                parity_done,
  output logic                low_pkt_valid,
  output logic                err,
  output logic                len_err
);

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] pkt_parity;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              parity_done_d;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              ld_byte;
  logic              direct_wr;
  logic              push_req;
  logic              push_ok;
  logic              drop;
  logic              pop;
  logic              parity_cap;
  logic              parity_rise;
  logic              buf_full;
  logic [DATA_W-1:0] buf_dout;
  dout_src_e         src;

  // The FSM's full_state strobe carries no datapath action here; the
  // holding buffer already reacts to fifo_full directly.
  logic unused_full_state;
  assign unused_full_state = full_state;

  assign addr        = bus.data_in[HDR_ADDR_LSB +: ADDR_W];
  assign addr_ok     = int'(addr) < NUM_CH;
  assign ld_byte     = ld_state & bus.pkt_valid;
  assign direct_wr   = ld_byte & ~bus.fifo_full & hold_empty;
  assign push_req    = ld_byte & (bus.fifo_full | ~hold_empty);
  assign pop         = laf_state & ~bus.fifo_full & ~hold_empty;
  assign push_ok     = push_req & (~buf_full | pop);
  assign drop        = push_req & ~push_ok;
  assign parity_cap  = ld_state & ~bus.pkt_valid;
  assign parity_rise = parity_done & ~parity_done_d;

  router_hold_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (HOLD_DEPTH)
  ) u_hold_buf (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_ok),
    .pop    (pop),
    .din    (bus.data_in),
    .dout   (buf_dout),
    .empty  (hold_empty),
    .full   (buf_full)
  );

  // Choose what, if anything, is written to the channel FIFO this cycle.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    src = SRC_NONE;
    if (lfd_state)      src = SRC_HDR;
    else if (direct_wr) src = SRC_DIN;
    else if (pop)       src = SRC_BUF;
  end

  // Fold the header and every byte that is actually kept into the parity.
  always_comb begin
    acc_next = acc;
    if (lfd_state)
      acc_next = DATA_W'(parity_fold(PAR_MAX_W'(acc_next), PAR_MAX_W'(header)));
    if (direct_wr | push_ok)
      acc_next = DATA_W'(parity_fold(PAR_MAX_W'(acc_next), PAR_MAX_W'(bus.data_in)));
  end

  // Output byte register: one-cycle latency from the selected source.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= (src != SRC_NONE);
      case (src)
        SRC_HDR: dout_q <= header;
        SRC_DIN: dout_q <= bus.data_in;
        SRC_BUF: dout_q <= buf_dout;
        default: dout_q <= dout_q;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

  // Per-packet state: header, parity accumulation, parity check, overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header        <= '0;
      acc           <= '0;
      pkt_parity    <= '0;
      parity_done   <= 1'b0;
      parity_done_d <= 1'b0;
      err           <= 1'b0;
      hold_ovf      <= 1'b0;
    end else begin
      parity_done_d <= parity_done;
      if (detect_add) begin
        if (bus.pkt_valid && addr_ok) header <= bus.data_in;
        acc         <= '0;
        pkt_parity  <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        hold_ovf    <= 1'b0;
      end else begin
        acc <= acc_next;
        if (parity_cap) begin
          pkt_parity  <= bus.data_in;
          parity_done <= 1'b1;
        end
        if (drop)        hold_ovf <= 1'b1;
        if (parity_rise) err      <= (acc != pkt_parity);
      end
    end
  end

  // End-of-payload flag for the FSM; its clear strobe wins over a new set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          low_pkt_valid <= 1'b0;
    else if (rst_int_reg) low_pkt_valid <= 1'b0;
    else if (parity_cap)  low_pkt_valid <= 1'b1;
  end

`ifdef PKT_LEN_CHECK_EN
  localparam int LEN_W = DATA_W - ADDR_W;

  // One spare bit so an overlong packet cannot wrap back to a match.
  logic [LEN_W:0] pay_cnt;

  // Count offered payload bytes (dropped ones included) and compare with
  // the header length field alongside the parity check.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else if (detect_add) begin
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (ld_byte && (pay_cnt != '1)) pay_cnt <= pay_cnt + 1'b1;
      if (parity_rise) len_err <= (pay_cnt != {1'b0, header[DATA_W-1:ADDR_W]});
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Self-checking bench for router_pkt_reg: directed packets followed by
// random ones. Stimulus feeds a queue-based reference model that pushes
// expected FIFO writes onto a scoreboard; a monitor pops and compares
// whenever dout_valid is seen. Packet-level checks cover parity, overflow
// and length outcomes.
module tb_router_pkt_reg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int NUM_CH     = 3;
  localparam int HOLD_DEPTH = 2;

  typedef logic [7:0] byte_q_t [$];

  logic clock = 1'b0;
  logic resetn;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic hold_empty, hold_ovf, parity_done, low_pkt_valid, err, len_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] m_hdr;
  logic [7:0] m_acc;
  logic [7:0] m_par;
  bit         m_pdone, m_ovf, m_lpv;
  int         m_cnt;
  logic [7:0] hold_q [$];
  logic [7:0] exp_q  [$];

  router_pkt_reg_if #(.DATA_W(DATA_W)) bus ();

  router_pkt_reg #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_CH     (NUM_CH),
    .HOLD_DEPTH (HOLD_DEPTH)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .bus           (bus.slave),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .hold_empty    (hold_empty),
    .hold_ovf      (hold_ovf),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .len_err       (len_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the oldest expectation.
  always @(negedge clock) begin
    if (resetn && bus.dout_valid) begin
      if (exp_q.size() == 0) check("unexpected_dout_valid", 1, 0);
      else                   check("dout", bus.dout, exp_q.pop_front());
    end
  end

  function automatic void model_reset();
    m_hdr = '0; m_acc = '0; m_par = '0;
    m_pdone = 0; m_ovf = 0; m_lpv = 0; m_cnt = 0;
    hold_q.delete();
    exp_q.delete();
  endfunction

  // Drive one cycle of strobes/data, advance the model, then compare the
  // status outputs just after the edge.
  task automatic step(input bit da, input bit lfd, input bit ld, input bit laf,
                      input bit ri, input bit pv, input logic [7:0] din, input bit ff);
    int sz;
    detect_add  = da;  lfd_state = lfd; ld_state = ld; laf_state = laf;
    rst_int_reg = ri;  full_state = ff & ld;
    bus.pkt_valid = pv; bus.data_in = din; bus.fifo_full = ff;
    sz = hold_q.size();
    if (da) begin
      if (pv && (int'(din[1:0]) < NUM_CH)) m_hdr = din;
      m_acc = '0; m_par = '0; m_pdone = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (lfd) begin
        exp_q.push_back(m_hdr);
        m_acc ^= m_hdr;
      end
      if (laf && !ff && sz > 0) exp_q.push_back(hold_q.pop_front());
      if (ld && pv) begin
        m_cnt++;
        if (!ff && sz == 0) begin
          exp_q.push_back(din);
          m_acc ^= din;
        end else if (hold_q.size() < HOLD_DEPTH) begin
          hold_q.push_back(din);
          m_acc ^= din;
        end else begin
          m_ovf = 1;
        end
      end
      if (ld && !pv) begin
        m_par = din; m_pdone = 1; m_lpv = 1;
      end
    end
    if (ri) m_lpv = 0;
    @(posedge clock);
    #1;
    check("hold_empty",    hold_empty,    hold_q.size() == 0);
    check("hold_ovf",      hold_ovf,      m_ovf);
    check("parity_done",   parity_done,   m_pdone);
    check("low_pkt_valid", low_pkt_valid, m_lpv);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  // Full packet: header, payload (full_mode 0 never full, 1 always full,
  // 2 random), parity byte (source XOR unless an explicit value is given),
  // then drain the holding buffer and clear low_pkt_valid.
  task automatic send_pkt(input logic [7:0] hdr, input byte_q_t pl, input int full_mode,
                          input bit use_par, input logic [7:0] par_val);
    logic [7:0] p;
    logic       exp_err, exp_len;
    bit         ff;
    int         n_drain;
    p = hdr;
    foreach (pl[i]) p ^= pl[i];
    if (use_par) p = par_val;
    step(1, 0, 0, 0, 0, 1, hdr, 0);
    check("err_after_detect", err, 0);
    check("len_err_after_detect", len_err, 0);
    step(0, 1, 0, 0, 0, 1, hdr, 0);
    foreach (pl[i]) begin
      ff = (full_mode == 1) ? 1'b1 : (full_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step(0, 0, 1, 0, 0, 1, pl[i], ff);
    end
    step(0, 0, 1, 0, 0, 0, p, 0);
    check("err_not_before_parity_done", err, 0);
    exp_err = (m_acc != m_par);
`ifdef PKT_LEN_CHECK_EN
    exp_len = (m_cnt != int'(m_hdr[7:2]));
`else
    exp_len = 1'b0;
`endif
    step(0, 0, 0, 1, 0, 0, 8'h00, 0);
    check("err", err, exp_err);
    check("len_err", len_err, exp_len);
    n_drain = hold_q.size();
    repeat (n_drain) step(0, 0, 0, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 1, 0, 8'h00, 0);
    check("err_held", err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t    pl;
    logic [7:0] hdr;
    logic [7:0] p;
    int         n, len, addr;

    resetn = 1'b0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0;
    bus.pkt_valid = 0; bus.data_in = '0; bus.fifo_full = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_dout",        bus.dout,       0);
    check("reset_dout_valid",  bus.dout_valid, 0);
    check("reset_hold_empty",  hold_empty,     1);
    check("reset_hold_ovf",    hold_ovf,       0);
    check("reset_parity_done", parity_done,    0);
    check("reset_low_pkt",     low_pkt_valid,  0);
    check("reset_err",         err,            0);
    check("reset_len_err",     len_err,        0);
    @(negedge clock);
    resetn = 1'b1;

    // 1: clean packet, header 05 payload A3 parity A6.
    pl = '{8'hA3};
    send_pkt(8'h05, pl, 0, 1, 8'hA6);

    // 2: same packet with a wrong parity byte; err clears on the next header.
    send_pkt(8'h05, pl, 0, 1, 8'h00);
    step(1, 0, 0, 0, 0, 1, 8'h0B, 0);
    check("err_cleared_by_detect", err, 0);

    // 3: header 0B has address 3 and is rejected; lfd replays the old header.
    step(0, 1, 0, 0, 0, 1, 8'h0B, 0);
    idle();

    // 4: both payload bytes arrive while full, then drain in order.
    pl = '{8'h11, 8'h22};
    send_pkt(8'h08, pl, 1, 0, 8'h00);

    // 5: one byte more than the buffer holds while full.
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0E, pl, 1, 0, 8'h00);
    check("ovf_sticky_until_detect", hold_ovf, 1);

    // 6: asynchronous reset in the middle of a buffered payload.
    step(1, 0, 0, 0, 0, 1, 8'h0D, 0);
    step(0, 1, 0, 0, 0, 1, 8'h0D, 0);
    step(0, 0, 1, 0, 0, 1, 8'h44, 1);
    step(0, 0, 1, 0, 0, 1, 8'h55, 0);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_dout",        bus.dout,       0);
    check("midrst_dout_valid",  bus.dout_valid, 0);
    check("midrst_hold_empty",  hold_empty,     1);
    check("midrst_parity_done", parity_done,    0);
    check("midrst_low_pkt",     low_pkt_valid,  0);
    model_reset();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    bus.pkt_valid = 0; bus.fifo_full = 0;
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b1;
    idle();
    step(0, 0, 0, 1, 0, 0, 8'h00, 0);
    idle();

    // Length field 3 with only two payload bytes.
    pl = '{8'h44, 8'h55};
    send_pkt(8'h0D, pl, 0, 0, 8'h00);

    // Random packets with random FIFO stalls and occasional bad parity or
    // length field.
    for (int k = 0; k < 40; k++) begin
      n    = $urandom_range(1, 5);
      addr = $urandom_range(0, NUM_CH - 1);
      len  = ($urandom_range(0, 3) == 0) ? n + 1 : n;
      hdr  = {6'(len), 2'(addr)};
      pl.delete();
      p = hdr;
      for (int i = 0; i < n; i++) begin
        pl.push_back(8'($urandom_range(0, 255)));
        p ^= pl[i];
      end
      if ($urandom_range(0, 3) == 0) p ^= 8'(1 << $urandom_range(0, 7));
      send_pkt(hdr, pl, 2, 1, p);
    end

    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
